// File: rtl/mc_axi_traffic_gen.sv
// AXI4 burst master: writes NUM_BURSTS INCR bursts of addr^SEED, reads them back and checks each beat.
// One transaction outstanding; channel hops on the handshake edge; every valid holds until its ready.
module mc_axi_traffic_gen #(
  parameter int          AXI_ID_WIDTH   = 4,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0100,
  parameter int          BURST_LEN      = 4,
  parameter int          NUM_BURSTS     = 2,
  parameter logic [31:0] SEED           = 32'hA5A5_0000,
  parameter int          TX_ID          = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [15:0]               err_cnt_o,
  output logic [31:0]               first_err_addr_o,
  output logic                      axi_awvalid_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_awid_o,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr_o,
  output logic [2:0]                axi_awsize_o,
  output logic [7:0]                axi_awlen_o,
  output logic [1:0]                axi_awburst_o,
  input  logic                      axi_awready_i,
  output logic                      axi_wvalid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_wdata_o,
  output logic [3:0]                axi_wstrb_o,
  output logic                      axi_wlast_o,
  input  logic                      axi_wready_i,
  input  logic                      axi_bvalid_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_bid_i,
  input  logic [1:0]                axi_bresp_i,
  output logic                      axi_bready_o,
  output logic                      axi_arvalid_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_arid_o,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr_o,
  output logic [2:0]                axi_arsize_o,
  output logic [7:0]                axi_arlen_o,
  output logic [1:0]                axi_arburst_o,
  input  logic                      axi_arready_i,
  input  logic                      axi_rvalid_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_rid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rlast_i,
  output logic                      axi_rready_o
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_L   = AXI_ID_WIDTH'(TX_ID);
  localparam logic [7:0]              LAST_K = 8'(BURST_LEN - 1);
  localparam logic [15:0]             LAST_B = 16'(NUM_BURSTS - 1);
  localparam logic [31:0]             STEP   = 32'(BURST_LEN * 4);

  typedef enum logic [2:0] {IDLE, WA, WD, WB, RA, RD, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] b_q;
  logic [7:0]  k_q;
  logic [31:0] addr_b_q;
  logic        done_q;
  logic [15:0] err_cnt_q;
  logic [31:0] first_err_q;
  logic [31:0] beat_addr, exp_data, err_addr;
  logic        err_ev, last_beat, rd_end;

  assign beat_addr = addr_b_q + {22'd0, k_q, 2'b00};
  assign exp_data  = beat_addr ^ SEED;
  assign last_beat = (k_q == LAST_K);
  assign rd_end    = axi_rvalid_i && (axi_rlast_i || last_beat);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i)       state_d = WA;
      WA:   if (axi_awready_i) state_d = WD;
      WD:   if (axi_wready_i && last_beat) state_d = WB;
      WB:   if (axi_bvalid_i)  state_d = (b_q == LAST_B) ? RA : WA;
      RA:   if (axi_arready_i) state_d = RD;
      RD:   if (rd_end)        state_d = (b_q == LAST_B) ? DONE : RA;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // At most one error event per cycle: a bad B response or one bad read beat.
  always_comb begin
    err_ev   = 1'b0;
    err_addr = addr_b_q;
    case (state_q)
      WB: err_ev = axi_bvalid_i && ((axi_bresp_i != 2'b00) || (axi_bid_i != ID_L));
      RD: begin
        err_ev   = axi_rvalid_i && ((32'(axi_rdata_i) != exp_data) || (axi_rresp_i != 2'b00) ||
                                    (axi_rid_i != ID_L) || (axi_rlast_i != last_beat));
        err_addr = beat_addr;
      end
      default: err_ev = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      b_q         <= '0;
      k_q         <= '0;
      addr_b_q    <= '0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          b_q         <= '0;
          k_q         <= '0;
          addr_b_q    <= BASE_ADDR;
          done_q      <= 1'b0;
          err_cnt_q   <= '0;
          first_err_q <= '0;
        end
        WD: if (axi_wready_i) k_q <= last_beat ? 8'd0 : k_q + 8'd1;
        WB: if (axi_bvalid_i) begin
          if (b_q == LAST_B) begin
            b_q      <= '0;
            addr_b_q <= BASE_ADDR;
          end else begin
            b_q      <= b_q + 16'd1;
            addr_b_q <= addr_b_q + STEP;
          end
        end
        RD: if (axi_rvalid_i) begin
          if (rd_end) begin
            k_q <= '0;
            if (b_q == LAST_B) begin
              done_q <= 1'b1;
            end else begin
              b_q      <= b_q + 16'd1;
              addr_b_q <= addr_b_q + STEP;
            end
          end else begin
            k_q <= k_q + 8'd1;
          end
        end
        default: ;
      endcase
      if (err_ev) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0)    first_err_q <= err_addr;
      end
    end
  end

  assign busy_o           = (state_q != IDLE) && (state_q != DONE);
  assign done_o           = done_q;
  assign pass_o           = done_q && (err_cnt_q == 16'd0);
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

  assign axi_awvalid_o = (state_q == WA);
  assign axi_awid_o    = ID_L;
  assign axi_awaddr_o  = AXI_ADDR_WIDTH'(addr_b_q);
  assign axi_awsize_o  = 3'b010;
  assign axi_awlen_o   = LAST_K;
  assign axi_awburst_o = 2'b01;

  assign axi_wvalid_o  = (state_q == WD);
  assign axi_wdata_o   = AXI_DATA_WIDTH'(exp_data);
  assign axi_wstrb_o   = 4'hF;
  assign axi_wlast_o   = last_beat;
  assign axi_bready_o  = (state_q == WB);

  assign axi_arvalid_o = (state_q == RA);
  assign axi_arid_o    = ID_L;
  assign axi_araddr_o  = AXI_ADDR_WIDTH'(addr_b_q);
  assign axi_arsize_o  = 3'b010;
  assign axi_arlen_o   = LAST_K;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = (state_q == RD);

endmodule
